// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg -- shared definitions for the SPI flash command arbiter.
// Holds the arbiter FSM state encoding, requester port indices and the
// opcode/address/data widths used by the arbiter and the SPI/SoC glue.
package spi_arb_pkg;

  localparam int CODE_W    = 8;
  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 32;
  localparam int NUM_PORTS = 2;

  // Requester indices: port 0 is the CPU bus, port 1 is fetch/DMA.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_e;

  // One-hot grant vector for a port index.
  function automatic logic [1:0] port_onehot(input logic idx);
    return (idx == PORT_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_arb_if.sv
// spi_arb_if -- requester and engine signals of the SPI arbiter.
//   p0_* / p1_*      : request, command and completion per requester
//   rdata, gnt       : shared read data and one-hot current owner
//   spi_*            : command bus to / status from the SPI engine
// Modports: slave = the arbiter, master = requesters plus engine.
interface spi_arb_if;
  import spi_arb_pkg::*;

  logic              p0_req,     p1_req;
  logic [CODE_W-1:0] p0_code,    p1_code;
  logic [ADDR_W-1:0] p0_addr,    p1_addr;
  logic              p0_tx_addr, p1_tx_addr;
  logic              p0_done,    p1_done;
  logic              p0_err,     p1_err;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        gnt;
  logic [CODE_W-1:0] spi_code;
  logic [ADDR_W-1:0] spi_addr;
  logic              spi_tx_addr;
  logic              spi_req;
  logic              spi_ready;
  logic [DATA_W-1:0] spi_rdata;

  modport slave (
    input  p0_req, p1_req, p0_code, p1_code, p0_addr, p1_addr,
           p0_tx_addr, p1_tx_addr, spi_ready, spi_rdata,
    output p0_done, p1_done, p0_err, p1_err, rdata, gnt,
           spi_code, spi_addr, spi_tx_addr, spi_req
  );

  modport master (
    output p0_req, p1_req, p0_code, p1_code, p0_addr, p1_addr,
           p0_tx_addr, p1_tx_addr, spi_ready, spi_rdata,
    input  p0_done, p1_done, p0_err, p1_err, rdata, gnt,
           spi_code, spi_addr, spi_tx_addr, spi_req
  );
endinterface

// File: rtl/spi_arb_rr_pick.sv
// spi_arb_rr_pick -- combinational two-way round-robin selector.
//   i_req : request vector (bit n = port n)
//   i_ptr : preferred port when both request
//   o_gnt : one-hot winner, zero when nobody requests
module spi_arb_rr_pick
  import spi_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  // Contention goes to the pointer; a lone request wins outright.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = port_onehot(i_ptr);
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/spi_arb.sv
// spi_arb -- arbitrates two requesters onto one SPI flash engine.
//   ck, rst_n : clock (rising edge) and async active-low reset
//   bus       : spi_arb_if.slave -- requester commands/completions,
//               engine command bus, shared read data and grant
// Parameters: TIMEOUT cycles allowed per transaction, N_PORTS (2).
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int N_PORTS = NUM_PORTS
) (
  input  logic       ck,
  input  logic       rst_n,
  spi_arb_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  arb_state_e         r_state, w_state_nxt;
  logic [N_PORTS-1:0] w_req;
  logic [1:0]         w_pick;
  logic               w_timeout, w_capture;
  logic [CNT_W-1:0]   r_cnt, w_cnt_inc;
  logic               r_ptr;
  logic [1:0]         r_gnt, r_done, r_err;
  logic               r_spi_req;
  logic [DATA_W-1:0]  r_rdata;
  logic [CODE_W-1:0]  r_code;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_tx_addr;

  assign w_req     = {bus.p1_req, bus.p0_req};
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  spi_arb_rr_pick u_rr_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  // Next-state decode; timeout wins in WAIT_BUSY, engine ready wins in WAIT_DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((w_req != 2'b00) && bus.spi_ready) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (w_cnt_inc == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = ST_RESP;
          w_timeout   = 1'b1;
        end else if (!bus.spi_ready) begin
          w_state_nxt = ST_WAIT_DONE;
        end else begin
          w_state_nxt = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.spi_ready) begin
          w_state_nxt = ST_RESP;
          w_capture   = 1'b1;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = ST_RESP;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: command latch, grant, timeout count, completion and read data.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= 2'b00;
      r_ptr     <= PORT_CPU;
      r_spi_req <= 1'b0;
      r_done    <= 2'b00;
      r_err     <= 2'b00;
      r_rdata   <= {DATA_W{1'b0}};
      r_code    <= {CODE_W{1'b0}};
      r_addr    <= {ADDR_W{1'b0}};
      r_tx_addr <= 1'b0;
      r_cnt     <= CNT_W'(0);
    end else begin
      // Start pulse is the registered image of ISSUE, so it lasts one cycle.
      r_spi_req <= (r_state == ST_ISSUE);
      r_done    <= 2'b00;
      r_err     <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_state_nxt == ST_ISSUE) begin
            r_gnt     <= w_pick;
            r_code    <= w_pick[PORT_DMA] ? bus.p1_code    : bus.p0_code;
            r_addr    <= w_pick[PORT_DMA] ? bus.p1_addr    : bus.p0_addr;
            r_tx_addr <= w_pick[PORT_DMA] ? bus.p1_tx_addr : bus.p0_tx_addr;
          end
        end
        ST_ISSUE: r_cnt <= CNT_W'(0);
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          r_cnt <= w_cnt_inc;
          if (w_state_nxt == ST_RESP) begin
            r_done <= r_gnt;
            r_err  <= w_timeout ? r_gnt : 2'b00;
            // Prefer the port that did not just finish.
            r_ptr  <= ~r_gnt[PORT_DMA];
          end
          if (w_capture) begin
            r_rdata <= bus.spi_rdata;
          end
        end
        ST_RESP: r_gnt <= 2'b00;
        default: r_gnt <= 2'b00;
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.spi_req     = r_spi_req;
  assign bus.spi_code    = r_code;
  assign bus.spi_addr    = r_addr;
  assign bus.spi_tx_addr = r_tx_addr;
  assign bus.rdata       = r_rdata;
  assign bus.p0_done     = r_done[PORT_CPU];
  assign bus.p1_done     = r_done[PORT_DMA];
  assign bus.p0_err      = r_err[PORT_CPU];
  assign bus.p1_err      = r_err[PORT_DMA];

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb -- directed bench for spi_arb with a transaction-timeline
// model compared against the DUT every cycle, plus literal checks.
module tb_spi_arb;
  import spi_arb_pkg::*;

  localparam int TMO = 16;

  logic ck = 1'b0;
  logic rst_n = 1'b0;
  always #5 ck = ~ck;

  spi_arb_if bus();

  spi_arb #(.TIMEOUT(TMO), .N_PORTS(2)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  // Requester drive
  logic        p_req  [2] = '{1'b0, 1'b0};
  logic [7:0]  p_code [2] = '{8'h00, 8'h00};
  logic [23:0] p_addr [2] = '{24'h0, 24'h0};
  logic        p_tx   [2] = '{1'b0, 1'b0};
  assign bus.p0_req = p_req[0];   assign bus.p1_req = p_req[1];
  assign bus.p0_code = p_code[0]; assign bus.p1_code = p_code[1];
  assign bus.p0_addr = p_addr[0]; assign bus.p1_addr = p_addr[1];
  assign bus.p0_tx_addr = p_tx[0]; assign bus.p1_tx_addr = p_tx[1];

  // Engine: on spi_req drops ready for eng_busy cycles, then returns eng_val.
  logic        eng_ready = 1'b1;
  logic [31:0] eng_rdata = 32'h0;
  logic        eng_hang = 1'b0;
  int          eng_busy = 3;
  logic [31:0] eng_val = 32'h0;
  int          eng_cnt = 0;
  assign bus.spi_ready = eng_ready;
  assign bus.spi_rdata = eng_rdata;
  always @(posedge ck) begin
    if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_ready <= 1'b1;
        eng_rdata <= eng_val;
      end
    end else if (bus.spi_req && !eng_hang) begin
      eng_ready <= 1'b0;
      eng_cnt   <= eng_busy;
    end
  end

  // Model: expected outputs, advanced once per clock from the inputs.
  logic [1:0]  e_gnt, e_done, e_err;
  logic        e_spi_req, e_tx;
  logic [31:0] e_rdata;
  logic [7:0]  e_code;
  logic [23:0] e_addr;
  int m_owner, m_n;
  bit m_resp, m_low, m_ptr;

  task automatic model_reset();
    e_gnt = 2'b00; e_done = 2'b00; e_err = 2'b00; e_spi_req = 1'b0;
    e_tx = 1'b0; e_rdata = 32'h0; e_code = 8'h00; e_addr = 24'h0;
    m_owner = -1; m_n = 0; m_resp = 1'b0; m_low = 1'b0; m_ptr = 1'b0;
  endtask

  task automatic model_finish(input bit timeout);
    e_done[m_owner] = 1'b1;
    e_err[m_owner]  = timeout;
    m_resp = 1'b1;
    m_ptr  = (m_owner == 0);
  endtask

  task automatic model_edge();
    logic [1:0] rq;
    int w;
    rq = {bus.p1_req, bus.p0_req};
    e_spi_req = 1'b0; e_done = 2'b00; e_err = 2'b00;
    if (m_resp) begin
      m_resp = 1'b0; m_owner = -1; e_gnt = 2'b00;
    end else if (m_owner < 0) begin
      if (rq != 2'b00 && bus.spi_ready) begin
        if (rq == 2'b11) w = m_ptr ? 1 : 0;
        else             w = rq[1] ? 1 : 0;
        m_owner = w; m_n = -1; m_low = 1'b0;
        e_gnt  = (w == 1) ? 2'b10 : 2'b01;
        e_code = (w == 1) ? bus.p1_code : bus.p0_code;
        e_addr = (w == 1) ? bus.p1_addr : bus.p0_addr;
        e_tx   = (w == 1) ? bus.p1_tx_addr : bus.p0_tx_addr;
      end
    end else if (m_n < 0) begin
      m_n = 0; e_spi_req = 1'b1;
    end else begin
      m_n++;
      if (m_low && bus.spi_ready) begin
        e_rdata = bus.spi_rdata;
        model_finish(1'b0);
      end else if (m_n == TMO - 1) begin
        model_finish(1'b1);
      end else if (!bus.spi_ready) begin
        m_low = 1'b1;
      end
    end
  endtask

  initial model_reset();

  // Per-cycle compare of every output against the model.
  always @(negedge ck) begin
    if (!rst_n) model_reset();
    checks++;
    if ({bus.gnt, bus.spi_req, bus.p1_done, bus.p0_done, bus.p1_err, bus.p0_err,
         bus.rdata, bus.spi_code, bus.spi_addr, bus.spi_tx_addr} !==
        {e_gnt, e_spi_req, e_done[1], e_done[0], e_err[1], e_err[0],
         e_rdata, e_code, e_addr, e_tx}) begin
      failures++;
      $display("FAIL model cyc=%0d got gnt=%b req=%b done=%b%b err=%b%b rd=%h code=%h addr=%h tx=%b want gnt=%b req=%b done=%b err=%b rd=%h code=%h addr=%h tx=%b",
               cyc, bus.gnt, bus.spi_req, bus.p1_done, bus.p0_done, bus.p1_err, bus.p0_err,
               bus.rdata, bus.spi_code, bus.spi_addr, bus.spi_tx_addr,
               e_gnt, e_spi_req, e_done, e_err, e_rdata, e_code, e_addr, e_tx);
    end
    if (rst_n) model_edge();
  end

  // Event monitor for literal timing checks.
  logic [1:0]  prev_gnt = 2'b00;
  int          gnt_q[$];
  int          t_gnt = 0, t_spi = 0, t_done = 0, n_done = 0;
  logic [23:0] d_addr = 24'h0;
  always @(negedge ck) begin
    if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
      gnt_q.push_back(bus.gnt[1] ? 1 : 0);
      t_gnt = cyc;
    end
    prev_gnt = bus.gnt;
    if (bus.spi_req) t_spi = cyc;
    if (bus.p0_done || bus.p1_done) begin
      t_done = cyc; d_addr = bus.spi_addr; n_done++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Raise a request, wait for reps completions (re-requesting or holding), then drop.
  task automatic port_txn(input int port, input logic [7:0] code, input logic [23:0] addr,
                          input logic tx, input int reps, input bit hold,
                          output int t_req, output logic err, output logic [31:0] rd);
    bit got;
    @(posedge ck); #1;
    p_code[port] = code; p_addr[port] = addr; p_tx[port] = tx; p_req[port] = 1'b1;
    t_req = cyc; err = 1'b0; rd = 32'h0;
    for (int r = 0; r < reps; r++) begin
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
        @(negedge ck);
        if ((port == 0) ? bus.p0_done : bus.p1_done) begin
          got = 1'b1;
          err = (port == 0) ? bus.p0_err : bus.p1_err;
          rd  = bus.rdata;
        end
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL done_wait port=%0d got=none want=done within 300 cycles", port);
      end
      @(posedge ck); #1;
      if (!hold || r == reps - 1) p_req[port] = 1'b0;
      if (!hold && r < reps - 1) begin
        @(posedge ck); #1;
        p_req[port] = 1'b1;
      end
    end
  endtask

  int tr0, tr1, nd;
  logic e0, e1;
  logic [31:0] r0, r1;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_spi_req", bus.spi_req, 1'b0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_cmd", {bus.spi_code, bus.spi_addr, bus.spi_tx_addr}, 33'h0);
    chk("rst_done_err", {bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err}, 4'h0);
    rst_n = 1'b1;

    // Basic read: 10-cycle engine.
    eng_busy = 10; eng_val = 32'h12345678;
    port_txn(0, 8'h03, 24'h000100, 1'b1, 1, 1'b0, tr0, e0, r0);
    chk("t1_spi_req_latency", t_spi - tr0, 2);
    chk("t1_done_latency", t_done - t_spi, 12);
    chk("t1_rdata", r0, 32'h12345678);
    chk("t1_err", e0, 1'b0);
    chk("t1_cmd", {bus.spi_code, bus.spi_addr, bus.spi_tx_addr}, {8'h03, 24'h000100, 1'b1});

    // Lone requester wins regardless of pointer (pointer now favours port 1).
    eng_busy = 3; eng_val = 32'hA5A50002; gnt_q.delete();
    port_txn(0, 8'h0B, 24'h00ABCD, 1'b1, 1, 1'b0, tr0, e0, r0);
    chk("t2_owner", gnt_q[0], 0);
    chk("t2_rdata", r0, 32'hA5A50002);
    eng_val = 32'hA5A50003; gnt_q.delete();
    port_txn(1, 8'h9F, 24'h000000, 1'b0, 1, 1'b0, tr1, e1, r1);
    chk("t3_owner", gnt_q[0], 1);
    chk("t3_rdata", r1, 32'hA5A50003);

    // Simultaneous requests with pointer on port 0.
    eng_val = 32'hA5A50004; gnt_q.delete();
    fork
      port_txn(0, 8'h03, 24'h001000, 1'b1, 1, 1'b0, tr0, e0, r0);
      port_txn(1, 8'h0B, 24'h002000, 1'b1, 1, 1'b0, tr1, e1, r1);
    join
    chk("t4_count", gnt_q.size(), 2);
    chk("t4_first", gnt_q[0], 0);
    chk("t4_second", gnt_q[1], 1);

    // p1 held high, p0 re-requests: grants alternate.
    eng_val = 32'hA5A50005; gnt_q.delete();
    fork
      port_txn(0, 8'h03, 24'h003000, 1'b1, 2, 1'b0, tr0, e0, r0);
      port_txn(1, 8'h03, 24'h004000, 1'b1, 2, 1'b1, tr1, e1, r1);
    join
    chk("t5_count", gnt_q.size(), 4);
    for (int i = 0; i < 4 && i < gnt_q.size(); i++) chk("t5_order", gnt_q[i], i % 2);

    // Engine never goes busy: timeout with error, rdata kept.
    eng_hang = 1'b1;
    port_txn(0, 8'h05, 24'h005000, 1'b0, 1, 1'b0, tr0, e0, r0);
    chk("t6_err", e0, 1'b1);
    chk("t6_timeout_cycle", t_done - t_gnt, 16);
    chk("t6_rdata_kept", r0, 32'hA5A50005);
    eng_hang = 1'b0; eng_val = 32'hC0DE0006;
    port_txn(1, 8'h03, 24'h006000, 1'b1, 1, 1'b0, tr1, e1, r1);
    chk("t6_next_err", e1, 1'b0);
    chk("t6_next_rdata", r1, 32'hC0DE0006);

    // Reset while waiting on the engine.
    eng_busy = 20; eng_val = 32'h0BAD0007;
    @(posedge ck); #1;
    p_code[0] = 8'h03; p_addr[0] = 24'h007000; p_tx[0] = 1'b1; p_req[0] = 1'b1;
    repeat (8) @(posedge ck);
    #1;
    nd = n_done;
    rst_n = 1'b0; p_req[0] = 1'b0;
    #1;
    chk("t7_rst_gnt", bus.gnt, 2'b00);
    chk("t7_rst_rdata", bus.rdata, 32'h0);
    chk("t7_rst_cmd", {bus.spi_code, bus.spi_addr, bus.spi_tx_addr, bus.spi_req}, 34'h0);
    repeat (2) @(posedge ck);
    #1;
    rst_n = 1'b1; eng_busy = 3;
    p_code[1] = 8'h0B; p_addr[1] = 24'h008000; p_tx[1] = 1'b1; p_req[1] = 1'b1;
    repeat (2) @(negedge ck);
    chk("t7_ready_blocks", bus.gnt, 2'b00);
    chk("t7_no_done", n_done - nd, 0);
    port_txn(1, 8'h0B, 24'h008000, 1'b1, 1, 1'b0, tr1, e1, r1);
    chk("t7_after_rdata", r1, 32'h0BAD0007);
    chk("t7_after_err", e1, 1'b0);

    // Address change and request drop after grant.
    eng_val = 32'h5EED0008;
    fork
      port_txn(0, 8'h0B, 24'h123456, 1'b0, 1, 1'b0, tr0, e0, r0);
      begin
        for (int k = 0; k < 50 && !bus.gnt[0]; k++) @(negedge ck);
        @(posedge ck); #1;
        p_addr[0] = 24'hFFFFFF; p_req[0] = 1'b0;
      end
    join
    chk("t8_addr_held", d_addr, 24'h123456);
    chk("t8_rdata", r0, 32'h5EED0008);

    repeat (5) @(posedge ck);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
